regfile_phased_bank: RTL and testbench

REGFILE_PHASED_BANK -- requirements
Module: regfile_phased_bank

---
 rtl/regfile_phased_bank.sv | 102 ++++++++++
 tb/tb_regfile_phased_bank.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/regfile_phased_bank.sv
// Register bank shared across a fixed-length instruction slot: reads sample at RD_PH,
// writes and single-entry undos commit at WR_PH, so a read never sees its own slot's write.
module regfile_phased_bank #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int RD_PORTS = 2,
  parameter int PHASES   = 10,
  parameter int RD_PH    = 6,
  parameter int WR_PH    = 8,
  parameter int ZERO_REG = 0,
  localparam int AW      = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH),
  localparam int PW      = ($clog2(PHASES) < 1) ? 1 : $clog2(PHASES)
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [PW-1:0]             phase,
  output logic                      instflag,
  input  logic                      rd_en,
  input  logic [RD_PORTS*AW-1:0]    rd_addr,
  output logic [RD_PORTS*WIDTH-1:0] rd_data,
  output logic                      rd_valid,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      undo_en,
  output logic                      undo_err,
  output logic                      jvalid
);

  if ((RD_PH >= WR_PH) || (WR_PH >= PHASES) || (PHASES < 2)) begin : g_bad_params
    $error("regfile_phased_bank: need RD_PH < WR_PH < PHASES and PHASES >= 2");
  end

  logic [PW-1:0]             r_phase;
  logic [WIDTH-1:0]          r_mem [DEPTH];
  logic [RD_PORTS*WIDTH-1:0] r_rd_data;
  logic                      r_rd_valid;
  logic                      r_undo_err;
  logic                      r_jvalid;
  logic [AW-1:0]             r_jaddr;
  logic [WIDTH-1:0]          r_jdata;

  // Addresses past the bank, and word 0 when hardwired, are neither stored nor read back.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [WIDTH-1:0] rd_word(input logic [AW-1:0] a);
    return addr_ok(a) ? r_mem[a] : '0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_undo_err <= 1'b0;
      r_jvalid   <= 1'b0;
      r_jaddr    <= '0;
      r_jdata    <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_undo_err <= 1'b0;
      r_phase    <= (r_phase == PW'(PHASES - 1)) ? '0 : r_phase + 1'b1;

      if ((r_phase == PW'(RD_PH)) && rd_en) begin
        for (int k = 0; k < RD_PORTS; k++)
          r_rd_data[k*WIDTH +: WIDTH] <= rd_word(rd_addr[k*AW +: AW]);
        r_rd_valid <= 1'b1;
      end
      if (r_phase == PW'(PHASES - 1)) r_rd_valid <= 1'b0;

      // A write wins over a simultaneous undo; the undo is then reported as rejected.
      if (r_phase == PW'(WR_PH)) begin
        if (wr_en) begin
          if (addr_ok(wr_addr)) begin
            r_mem[wr_addr] <= wr_data;
            r_jaddr        <= wr_addr;
            r_jdata        <= r_mem[wr_addr];
            r_jvalid       <= 1'b1;
          end
          if (undo_en) r_undo_err <= 1'b1;
        end else if (undo_en) begin
          if (r_jvalid) begin
            r_mem[r_jaddr] <= r_jdata;
            r_jvalid       <= 1'b0;
          end else begin
            r_undo_err <= 1'b1;
          end
        end
      end
    end
  end

  assign phase    = r_phase;
  assign instflag = (r_phase == '0);
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign undo_err = r_undo_err;
  assign jvalid   = r_jvalid;

endmodule

// File: tb/tb_regfile_phased_bank.sv
// Directed bench: u_dut uses defaults, u_z has ZERO_REG=1 and DEPTH=20; both share stimulus.
module tb_regfile_phased_bank;

  logic        clk;
  logic        reset;
  logic        rd_en, wr_en, undo_en;
  logic [9:0]  rd_addr;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  phase, z_phase;
  logic        instflag, z_instflag;
  logic [31:0] rd_data, z_rd_data;
  logic        rd_valid, z_rd_valid, undo_err, z_undo_err, jvalid, z_jvalid;

  int n_cmp = 0;
  int n_err = 0;

  regfile_phased_bank u_dut (
    .clk(clk), .reset(reset), .phase(phase), .instflag(instflag),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .undo_en(undo_en), .undo_err(undo_err), .jvalid(jvalid)
  );

  regfile_phased_bank #(.DEPTH(20), .ZERO_REG(1)) u_z (
    .clk(clk), .reset(reset), .phase(z_phase), .instflag(z_instflag),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(z_rd_data), .rd_valid(z_rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .undo_en(undo_en), .undo_err(z_undo_err), .jvalid(z_jvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd_en;
    logic [4:0]  a0, a1;
    logic        wr_en;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic        undo;
    logic [15:0] e0, e1;
    logic        ev, euerr, ejv;
    logic        zc;
    logic [15:0] z0, z1;
    logic        zjv;
  } vec_t;

  vec_t tbl_a [11];
  vec_t tbl_b [6];

  function automatic vec_t mk(logic re, logic [4:0] a0, logic [4:0] a1, logic we,
                              logic [4:0] wa, logic [15:0] wd, logic un,
                              logic [15:0] e0, logic [15:0] e1, logic ev, logic eu,
                              logic ejv, logic zc, logic [15:0] z0, logic [15:0] z1,
                              logic zjv);
    vec_t v;
    v.rd_en = re; v.a0 = a0; v.a1 = a1; v.wr_en = we; v.wa = wa; v.wd = wd;
    v.undo = un; v.e0 = e0; v.e1 = e1; v.ev = ev; v.euerr = eu; v.ejv = ejv;
    v.zc = zc; v.z0 = z0; v.z1 = z1; v.zjv = zjv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs are held for the whole slot so off-phase sampling would be exposed.
  task automatic run_slot(input vec_t v, input string tag);
    rd_en = v.rd_en; rd_addr = {v.a1, v.a0};
    wr_en = v.wr_en; wr_addr = v.wa; wr_data = v.wd; undo_en = v.undo;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 6) chk({tag, " valid_pre"}, 32'(rd_valid), 32'd0);
      if (c == 7) begin
        chk({tag, " phase7"}, 32'(phase), 32'd7);
        chk({tag, " rd0"}, 32'(rd_data[15:0]), 32'(v.e0));
        chk({tag, " rd1"}, 32'(rd_data[31:16]), 32'(v.e1));
        chk({tag, " valid"}, 32'(rd_valid), 32'(v.ev));
        if (v.zc) begin
          chk({tag, " z_rd0"}, 32'(z_rd_data[15:0]), 32'(v.z0));
          chk({tag, " z_rd1"}, 32'(z_rd_data[31:16]), 32'(v.z1));
          chk({tag, " z_valid"}, 32'(z_rd_valid), 32'(v.ev));
        end
      end
      if (c == 9) begin
        chk({tag, " undo_err"}, 32'(undo_err), 32'(v.euerr));
        chk({tag, " jvalid"}, 32'(jvalid), 32'(v.ejv));
        if (v.zc) begin
          chk({tag, " z_undo_err"}, 32'(z_undo_err), 32'd0);
          chk({tag, " z_jvalid"}, 32'(z_jvalid), 32'(v.zjv));
        end
      end
      if (c == 10) begin
        chk({tag, " wrap_phase"}, 32'(phase), 32'd0);
        chk({tag, " instflag"}, 32'(instflag), 32'd1);
        chk({tag, " valid_end"}, 32'(rd_valid), 32'd0);
        chk({tag, " uerr_end"}, 32'(undo_err), 32'd0);
      end
    end
  endtask

  initial begin
    //                re a0  a1  we wa  wd        un e0        e1        ev eu jv zc z0 z1 zjv
    tbl_a[0]  = mk(0, 0,  0,  1, 1,  16'hAAAA, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    tbl_a[1]  = mk(1, 1,  2,  0, 0,  16'h0000, 0, 16'hAAAA, 16'h0000, 1, 0, 1, 0, 0, 0, 0);
    tbl_a[2]  = mk(0, 0,  0,  1, 3,  16'h1234, 0, 16'hAAAA, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    tbl_a[3]  = mk(1, 3,  1,  1, 3,  16'hBEEF, 0, 16'h1234, 16'hAAAA, 1, 0, 1, 0, 0, 0, 0);
    tbl_a[4]  = mk(1, 3,  2,  0, 0,  16'h0000, 1, 16'hBEEF, 16'h0000, 1, 0, 0, 0, 0, 0, 0);
    tbl_a[5]  = mk(1, 3,  2,  0, 0,  16'h0000, 1, 16'h1234, 16'h0000, 1, 1, 0, 0, 0, 0, 0);
    tbl_a[6]  = mk(1, 3,  4,  0, 0,  16'h0000, 0, 16'h1234, 16'h0000, 1, 0, 0, 0, 0, 0, 0);
    tbl_a[7]  = mk(1, 4,  3,  1, 4,  16'h5555, 1, 16'h0000, 16'h1234, 1, 1, 1, 0, 0, 0, 0);
    tbl_a[8]  = mk(1, 4,  1,  0, 0,  16'h0000, 0, 16'h5555, 16'hAAAA, 1, 0, 1, 0, 0, 0, 0);
    tbl_a[9]  = mk(1, 4,  5,  0, 0,  16'h0000, 1, 16'h5555, 16'h0000, 1, 0, 0, 0, 0, 0, 0);
    tbl_a[10] = mk(1, 4,  31, 1, 5,  16'h0505, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 0, 0, 0);
    // After the mid-slot reset: both banks cleared, then the hardwired-zero checks.
    tbl_b[0]  = mk(1, 5,  1,  0, 0,  16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 0, 0, 0);
    tbl_b[1]  = mk(0, 0,  0,  1, 7,  16'h0777, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 0, 1);
    tbl_b[2]  = mk(0, 0,  0,  1, 0,  16'hFFFF, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 0, 1);
    tbl_b[3]  = mk(0, 0,  0,  1, 25, 16'hFFFF, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 0, 1);
    tbl_b[4]  = mk(1, 0,  25, 0, 0,  16'h0000, 0, 16'hFFFF, 16'hFFFF, 1, 0, 1, 1, 16'h0000, 16'h0000, 1);
    tbl_b[5]  = mk(1, 7,  25, 0, 0,  16'h0000, 0, 16'h0777, 16'hFFFF, 1, 0, 1, 1, 16'h0777, 16'h0000, 1);

    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; undo_en = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst phase", 32'(phase), 32'd0);
    chk("rst instflag", 32'(instflag), 32'd1);
    chk("rst rd_data", rd_data, 32'd0);
    chk("rst rd_valid", 32'(rd_valid), 32'd0);
    chk("rst jvalid", 32'(jvalid), 32'd0);
    chk("rst undo_err", 32'(undo_err), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_slot(tbl_a[i], $sformatf("a%0d", i));

    // Reset lands at phase 7 while a write to address 5 is pending for phase 8.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 16'h9999; rd_en = 1'b0; undo_en = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre-reset phase", 32'(phase), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    chk("mid-reset phase", 32'(phase), 32'd0);
    chk("mid-reset instflag", 32'(instflag), 32'd1);
    chk("mid-reset jvalid", 32'(jvalid), 32'd0);
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0;
    chk("post-reset phase", 32'(phase), 32'd0);
    @(negedge clk);
    chk("restart phase", 32'(phase), 32'd1);
    chk("restart instflag", 32'(instflag), 32'd0);
    repeat (9) @(negedge clk);
    chk("restart wrap", 32'(phase), 32'd0);

    for (int i = 0; i < 6; i++) run_slot(tbl_b[i], $sformatf("b%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
